// File: rtl/dsa_avalon_host_bridge_if.sv
// dsa_avalon_host_bridge_if: Avalon-MM slave command/response and DSA host-strobe bundle
interface dsa_avalon_host_bridge_if #(parameter int ADDR_WIDTH = 16);
   logic [ADDR_WIDTH-1:0] avs_address;
   logic                  avs_read;
   logic                  avs_write;
   logic [3:0]            avs_byteenable;
   logic [31:0]           avs_writedata;
   logic [31:0]           avs_readdata;
   logic                  avs_waitrequest;
   logic                  h_wr_en;
   logic                  h_rd_en;
   logic [15:0]           h_addr;
   logic [31:0]           h_wdata;
   logic [31:0]           h_rdata;
   logic                  h_rvalid;
   modport slave (
      input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata, h_rdata, h_rvalid,
      output avs_readdata, avs_waitrequest, h_wr_en, h_rd_en, h_addr, h_wdata
   );
   modport master (
      output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata, h_rdata, h_rvalid,
      input  avs_readdata, avs_waitrequest, h_wr_en, h_rd_en, h_addr, h_wdata
   );
endinterface

// File: rtl/dsa_avalon_host_bridge.sv
// dsa_avalon_host_bridge: Avalon-MM slave to single-cycle DSA strobes, partial writes done as RMW.
// Optional read timeout enabled by defining DSA_BRIDGE_TIMEOUT_EN.
module dsa_avalon_host_bridge #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   dsa_avalon_host_bridge_if.slave  bus,
   input  logic                     err_clr,
   output logic                     busy,
   output logic                     err_timeout
);
   typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, MERGE, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] rdata_q, rdata_d, h_wdata_q, h_wdata_d, wdata_q, wdata_d, merged;
   logic [15:0] h_addr_q, h_addr_d;
   logic [3:0]  be_q, be_d;
   logic        rmw_q, rmw_d, wait_q, wait_d, wr_q, wr_d, rd_q, rd_d, busy_q, busy_d;
   logic        timeout;
   for (genvar i = 0; i < 4; i++) begin : g_m
      assign merged[8*i+:8] = be_q[i] ? wdata_q[8*i+:8] : h_wdata_q[8*i+:8];
   end
`ifdef DSA_BRIDGE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   assign timeout = state_q == RD_WAIT && !bus.h_rvalid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      cnt_d = state_q == RD_WAIT ? cnt_q + 1'b1 : '0;
      err_d = timeout | (err_q & ~err_clr);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   assign err_timeout = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign timeout        = 1'b0;
   assign err_timeout    = 1'b0;
`endif
   always_comb begin
      state_d   = state_q;
      rdata_d   = rdata_q;
      h_wdata_d = h_wdata_q;
      wdata_d   = wdata_q;
      h_addr_d  = h_addr_q;
      be_d      = be_q;
      rmw_d     = rmw_q;
      case (state_q)
         IDLE: if (bus.avs_write || bus.avs_read) begin
            h_addr_d  = 16'(bus.avs_address);
            wdata_d   = bus.avs_writedata;
            h_wdata_d = bus.avs_writedata;
            be_d      = bus.avs_byteenable;
            rmw_d     = bus.avs_write;
            state_d   = !bus.avs_write ? RD : bus.avs_byteenable == 4'hF ? WR :
                        bus.avs_byteenable == 4'h0 ? DONE : RD;
         end
         WR:      state_d = DONE;
         RD:      state_d = RD_WAIT;
         // h_wdata temporarily holds the old word during RMW so MERGE can splice it
         RD_WAIT: if (bus.h_rvalid) begin
            state_d   = rmw_q ? MERGE : DONE;
            rdata_d   = rmw_q ? rdata_q : bus.h_rdata;
            h_wdata_d = rmw_q ? bus.h_rdata : h_wdata_q;
         end else if (timeout) begin
            state_d = DONE;
            rdata_d = 32'hDEADBEEF;
         end
         MERGE: begin
            h_wdata_d = merged;
            state_d   = WR;
         end
         default: state_d = IDLE;
      endcase
      wr_d   = state_d == WR;
      rd_d   = state_d == RD;
      wait_d = state_d != DONE;
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         rdata_q   <= '0;
         h_wdata_q <= '0;
         wdata_q   <= '0;
         h_addr_q  <= '0;
         be_q      <= '0;
         rmw_q     <= 1'b0;
         wait_q    <= 1'b1;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rdata_q   <= rdata_d;
         h_wdata_q <= h_wdata_d;
         wdata_q   <= wdata_d;
         h_addr_q  <= h_addr_d;
         be_q      <= be_d;
         rmw_q     <= rmw_d;
         wait_q    <= wait_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         busy_q    <= busy_d;
      end
   assign bus.avs_readdata    = rdata_q;
   assign bus.avs_waitrequest = wait_q;
   assign bus.h_wr_en         = wr_q;
   assign bus.h_rd_en         = rd_q;
   assign bus.h_addr          = h_addr_q;
   assign bus.h_wdata         = h_wdata_q;
   assign busy                = busy_q;
endmodule

// File: tb/tb_dsa_avalon_host_bridge.sv
// tb_dsa_avalon_host_bridge: table-driven Avalon transactions with a scoreboard queue,
// plus hand sequences for stray h_rvalid, mid-transaction reset and optional timeout.
module tb_dsa_avalon_host_bridge;
   localparam int TO = 8;
   logic clk = 1'b0, reset = 1'b1, err_clr = 1'b0, busy, err_timeout;
   always #5 clk = ~clk;
   dsa_avalon_host_bridge_if #(.ADDR_WIDTH(16)) bus ();
   dsa_avalon_host_bridge #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .bus(bus), .err_clr(err_clr), .busy(busy), .err_timeout(err_timeout)
   );
   typedef struct {
      logic        wr;
      logic        rd;
      logic [15:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] resp;
      int          dly;
      int          exp_wr;
      int          exp_rd;
      int          exp_lat;
      logic [31:0] exp_hwdata;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[8];
   vec_t exp_q[$];
   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic do_txn(input vec_t v);
      int cyc, rv_at, n_wr, n_rd, lat;
      logic [31:0] wd_seen, rdata_seen, busy_seen;
      logic [15:0] ad_seen;
      vec_t e;
      exp_q.push_back(v);
      cyc = 0; rv_at = -1; n_wr = 0; n_rd = 0; lat = -1;
      wd_seen = 'x; ad_seen = 'x; rdata_seen = 'x; busy_seen = 'x;
      bus.avs_read = v.rd; bus.avs_write = v.wr; bus.avs_address = v.addr;
      bus.avs_byteenable = v.be; bus.avs_writedata = v.wdata;
      while (lat < 0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.h_rd_en) begin
            n_rd++;
            ad_seen = bus.h_addr;
            if (v.dly > 0) rv_at = cyc + v.dly;
         end
         if (bus.h_wr_en) begin
            n_wr++;
            ad_seen = bus.h_addr;
            wd_seen = bus.h_wdata;
         end
         bus.h_rvalid = cyc == rv_at;
         bus.h_rdata  = cyc == rv_at ? v.resp : 32'h0;
         if (!bus.avs_waitrequest) begin
            lat = cyc;
            rdata_seen = bus.avs_readdata;
            busy_seen = 32'(busy);
            bus.avs_read = 1'b0;
            bus.avs_write = 1'b0;
         end
      end
      bus.h_rvalid = 1'b0;
      e = exp_q.pop_front();
      chk("latency", lat, e.exp_lat);
      chk("readdata", rdata_seen, e.exp_rdata);
      chk("busy_done", busy_seen, 1);
      chk("n_wr", n_wr, e.exp_wr);
      chk("n_rd", n_rd, e.exp_rd);
      if (e.exp_wr > 0) chk("h_wdata", wd_seen, e.exp_hwdata);
      if (e.exp_wr + e.exp_rd > 0) chk("h_addr", 32'(ad_seen), 32'(e.addr));
      @(negedge clk);
      chk("wait_one_cycle", bus.avs_waitrequest, 1);
      chk("busy_idle", busy, 0);
   endtask
   initial begin
      bus.avs_read = 0; bus.avs_write = 0; bus.avs_address = 0; bus.avs_byteenable = 0;
      bus.avs_writedata = 0; bus.h_rdata = 0; bus.h_rvalid = 0;
      vecs[0] = '{1, 0, 16'h0010, 4'hF, 32'h12345678, 32'h0,        0, 1, 0, 2, 32'h12345678, 32'h0};
      vecs[1] = '{0, 1, 16'h0010, 4'h0, 32'h0,        32'hCAFEF00D, 3, 0, 1, 5, 32'h0,        32'hCAFEF00D};
      vecs[2] = '{1, 0, 16'h0020, 4'h5, 32'hAABBCCDD, 32'h11223344, 1, 1, 1, 5, 32'h11BB33DD, 32'hCAFEF00D};
      vecs[3] = '{1, 0, 16'h0030, 4'h0, 32'h99999999, 32'h0,        0, 0, 0, 1, 32'h0,        32'hCAFEF00D};
      vecs[4] = '{0, 1, 16'hFFFF, 4'h0, 32'h0,        32'h0BADF00D, 1, 0, 1, 3, 32'h0,        32'h0BADF00D};
      vecs[5] = '{1, 1, 16'h0040, 4'hF, 32'h5A5A5A5A, 32'h0,        0, 1, 0, 2, 32'h5A5A5A5A, 32'h0BADF00D};
      vecs[6] = '{1, 0, 16'h1234, 4'hE, 32'h01020304, 32'hA0B0C0D0, 2, 1, 1, 6, 32'h010203D0, 32'h0BADF00D};
      vecs[7] = '{1, 0, 16'h4321, 4'h8, 32'hFF000000, 32'h00ABCDEF, 1, 1, 1, 5, 32'hFFABCDEF, 32'h0BADF00D};
      repeat (3) @(negedge clk);
      chk("rst_wait_in_reset", bus.avs_waitrequest, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_wait", bus.avs_waitrequest, 1);
      chk("rst_readdata", bus.avs_readdata, 0);
      chk("rst_wr_en", bus.h_wr_en, 0);
      chk("rst_rd_en", bus.h_rd_en, 0);
      chk("rst_h_addr", 32'(bus.h_addr), 0);
      chk("rst_h_wdata", bus.h_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      for (int i = 0; i < 8; i++) do_txn(vecs[i]);
      bus.h_rvalid = 1'b1; bus.h_rdata = 32'h55555555;
      @(negedge clk);
      bus.h_rvalid = 1'b0;
      @(negedge clk);
      chk("stray_rvalid_readdata", bus.avs_readdata, 32'h0BADF00D);
      chk("stray_rvalid_busy", busy, 0);
      chk("stray_rvalid_wait", bus.avs_waitrequest, 1);
      bus.avs_read = 1'b1; bus.avs_address = 16'h0050;
      @(negedge clk);
      chk("mid_rd_en", bus.h_rd_en, 1);
      @(negedge clk);
      chk("mid_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_wait", bus.avs_waitrequest, 1);
      chk("mid_rst_readdata", bus.avs_readdata, 0);
      chk("mid_rst_busy", busy, 0);
      bus.avs_read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus.h_rvalid = 1'b1; bus.h_rdata = 32'h77777777;
      @(negedge clk);
      bus.h_rvalid = 1'b0;
      chk("late_rv_rd_en", bus.h_rd_en, 0);
      chk("late_rv_wr_en", bus.h_wr_en, 0);
      @(negedge clk);
      chk("late_rv_readdata", bus.avs_readdata, 0);
      chk("late_rv_wait", bus.avs_waitrequest, 1);
      chk("late_rv_busy", busy, 0);
`ifdef DSA_BRIDGE_TIMEOUT_EN
      do_txn('{0, 1, 16'h0060, 4'h0, 32'h0, 32'h0, 0, 0, 1, TO + 2, 32'h0, 32'hDEADBEEF});
      chk("timeout_err_set", err_timeout, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("timeout_err_clr", err_timeout, 0);
`else
      chk("err_tied_low", err_timeout, 0);
`endif
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
